gpio_in_filter: RTL and testbench

Input-side companion to the bidirectional GPIO output mux. Takes raw pin values read back from the GPIO port and produces clean per-pin levels for the register file and the function modules:
- two-flop synchronisation
- optional per-pin glitch filter
- rise/fall edge pulses
- sticky edge latches with write-1-to-clear

Sits between the pin read path and the bus-side input registers.

---
 rtl/gpio_in_pkg.sv | 14 +
 rtl/gpio_in_filt_bit.sv | 90 +++++++++
 rtl/gpio_in_filter.sv | 70 +++++++
 tb/tb_gpio_in_filter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// Shared constants and types for the GPIO input filter block.
package gpio_in_pkg;

    localparam int IO_WIDTH_DEF   = 36;
    localparam int FILT_WIDTH_DEF = 8;

    typedef logic [FILT_WIDTH_DEF-1:0] filt_cnt_t;

    typedef enum logic {
        STABLE,
        COUNTING
    } filt_state_e;

endpackage

// File: rtl/gpio_in_filt_bit.sv
// One GPIO pin: glitch filter state machine, edge pulses and sticky edge latches.
module gpio_in_filt_bit
    import gpio_in_pkg::*;
#(
    parameter int FiltWidth = FILT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 level,
    input  logic                 vld,
    input  logic                 en,
    input  logic [FiltWidth-1:0] filt_time,
    input  logic                 sample_tick,
    input  logic                 latch_clr,
    output logic                 filt_data,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 rise_latch,
    output logic                 fall_latch
);

    filt_state_e          state;
    logic [FiltWidth-1:0] cnt;
    logic                 prev;
    logic                 armed;
    logic                 active;
    logic                 fire;
    logic [FiltWidth:0]   cnt_inc;

    // The increment is one bit wider so that a lowered filt_time can never wrap the compare.
    always_comb begin
        active  = en && (filt_time != '0);
        cnt_inc = {1'b0, cnt} + {{FiltWidth{1'b0}}, 1'b1};
        fire    = sample_tick && (cnt_inc >= {1'b0, filt_time});
    end

    // NOTE: all state here uses non-blocking assignments so every right-hand side
    // sees the pre-edge value; prev and the pulses depend on that ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STABLE;
            cnt        <= '0;
            filt_data  <= 1'b0;
            prev       <= 1'b0;
            armed      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            rise_latch <= 1'b0;
            fall_latch <= 1'b0;
        end else begin
            if (!active) begin
                state     <= STABLE;
                cnt       <= '0;
                filt_data <= level;
            end else begin
                case (state)
                    STABLE: begin
                        if (level != filt_data) state <= COUNTING;
                    end
                    COUNTING: begin
                        if (level == filt_data) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (fire) begin
                            state     <= STABLE;
                            cnt       <= '0;
                            filt_data <= level;
                        end else if (sample_tick) begin
                            cnt <= cnt_inc[FiltWidth-1:0];
                        end
                    end
                    default: begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
                endcase
            end

            // Edges stay muted until the level captured after reset has been absorbed.
            armed      <= armed | (vld & (level == filt_data));
            prev       <= filt_data;
            rise_pulse <= armed & filt_data & ~prev;
            fall_pulse <= armed & ~filt_data & prev;
            // Set has priority over a simultaneous clear.
            rise_latch <= rise_pulse | (rise_latch & ~latch_clr);
            fall_latch <= fall_pulse | (fall_latch & ~latch_clr);
        end
    end

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop sync, per-pin glitch filter, edge pulses, sticky latches.
// Optional GPIO_IN_INVERT_EN adds a per-pin invert port applied after synchronisation.
module gpio_in_filter
    import gpio_in_pkg::*;
#(
    parameter int IOWidth   = IO_WIDTH_DEF,
    parameter int FiltWidth = FILT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IOWidth-1:0]   pin_in,
    input  logic [IOWidth-1:0]   filt_en,
    input  logic [FiltWidth-1:0] filt_time,
    input  logic                 sample_tick,
    input  logic [IOWidth-1:0]   latch_clr,
`ifdef GPIO_IN_INVERT_EN
    input  logic [IOWidth-1:0]   invert,
`endif
    output logic [IOWidth-1:0]   filt_data,
    output logic [IOWidth-1:0]   rise_pulse,
    output logic [IOWidth-1:0]   fall_pulse,
    output logic [IOWidth-1:0]   rise_latch,
    output logic [IOWidth-1:0]   fall_latch
);

    logic [IOWidth-1:0] sync1;
    logic [IOWidth-1:0] sync2;
    logic [IOWidth-1:0] level;
    logic [1:0]         vld;

    // vld[1] marks the first cycle sync2 holds a pin value sampled after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            vld   <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
        end
    end

`ifdef GPIO_IN_INVERT_EN
    assign level = sync2 ^ invert;
`else
    assign level = sync2;
`endif

    for (genvar i = 0; i < IOWidth; i++) begin : g_pin
        gpio_in_filt_bit #(
            .FiltWidth (FiltWidth)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .level       (level[i]),
            .vld         (vld[1]),
            .en          (filt_en[i]),
            .filt_time   (filt_time),
            .sample_tick (sample_tick),
            .latch_clr   (latch_clr[i]),
            .filt_data   (filt_data[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .rise_latch  (rise_latch[i]),
            .fall_latch  (fall_latch[i])
        );
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed plus randomized bench for gpio_in_filter against a cycle-level reference model.
module tb_gpio_in_filter;
    import gpio_in_pkg::*;

    localparam int W  = IO_WIDTH_DEF;
    localparam int FW = FILT_WIDTH_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  pin_in;
    logic [W-1:0]  filt_en;
    filt_cnt_t     filt_time;
    logic          sample_tick;
    logic [W-1:0]  latch_clr;
    logic [W-1:0]  invert;
    logic [W-1:0]  filt_data, rise_pulse, fall_pulse, rise_latch, fall_latch;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tick_per = -1;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_filt, m_prev, m_rp, m_fp, m_rl, m_fl, m_settled;
    bit           pending [W];
    int           ticks_held [W];
    int           m_since_rst;

    gpio_in_filter #(.IOWidth(W), .FiltWidth(FW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pin_in      (pin_in),
        .filt_en     (filt_en),
        .filt_time   (filt_time),
        .sample_tick (sample_tick),
        .latch_clr   (latch_clr),
`ifdef GPIO_IN_INVERT_EN
        .invert      (invert),
`endif
        .filt_data   (filt_data),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .rise_latch  (rise_latch),
        .fall_latch  (fall_latch)
    );

    always #5 clk = ~clk;

    // Applies the behavioural rules to the inputs seen at the clock edge just taken.
    task automatic model_step();
        logic [W-1:0] lvl, nf;
        if (reset) begin
            {m_s1, m_s2, m_filt, m_prev, m_rp, m_fp, m_rl, m_fl, m_settled} = '0;
            for (int i = 0; i < W; i++) begin
                pending[i]    = 1'b0;
                ticks_held[i] = 0;
            end
            m_since_rst = 0;
            return;
        end
        lvl = m_s2 ^ invert;
        nf  = m_filt;
        for (int i = 0; i < W; i++) begin
            if (!filt_en[i] || filt_time == 0) begin
                nf[i] = lvl[i];
                pending[i] = 1'b0;
                ticks_held[i] = 0;
            end else if (lvl[i] == m_filt[i]) begin
                pending[i] = 1'b0;
                ticks_held[i] = 0;
            end else if (!pending[i]) begin
                pending[i] = 1'b1;
            end else if (sample_tick) begin
                if (ticks_held[i] + 1 >= int'(filt_time)) begin
                    nf[i] = lvl[i];
                    pending[i] = 1'b0;
                    ticks_held[i] = 0;
                end else begin
                    ticks_held[i]++;
                end
            end
        end
        m_rl = m_rp | (m_rl & ~latch_clr);
        m_fl = m_fp | (m_fl & ~latch_clr);
        m_rp = m_settled & m_filt & ~m_prev;
        m_fp = m_settled & ~m_filt & m_prev;
        if (m_since_rst >= 2) m_settled = m_settled | ~(lvl ^ m_filt);
        m_prev = m_filt;
        m_filt = nf;
        m_s2   = m_s1;
        m_s1   = pin_in;
        if (m_since_rst < 2) m_since_rst++;
    endtask

    task automatic check_all(input string tag);
        n_vec += 5;
        assert (filt_data === m_filt) else begin
            n_err++; $error("FAIL %s filt_data got %h want %h", tag, filt_data, m_filt);
        end
        assert (rise_pulse === m_rp) else begin
            n_err++; $error("FAIL %s rise_pulse got %h want %h", tag, rise_pulse, m_rp);
        end
        assert (fall_pulse === m_fp) else begin
            n_err++; $error("FAIL %s fall_pulse got %h want %h", tag, fall_pulse, m_fp);
        end
        assert (rise_latch === m_rl) else begin
            n_err++; $error("FAIL %s rise_latch got %h want %h", tag, rise_latch, m_rl);
        end
        assert (fall_latch === m_fl) else begin
            n_err++; $error("FAIL %s fall_latch got %h want %h", tag, fall_latch, m_fl);
        end
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_err++; $error("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    task automatic expect_zero(input string tag, input logic [W-1:0] got);
        n_vec++;
        assert (got === '0) else begin
            n_err++; $error("FAIL %s got %h want 0", tag, got);
        end
    endtask

    // One clock: update the model at the edge, sample 1 ns later, then set the next tick.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        cyc++;
        if (tick_per > 0)       sample_tick = (cyc % tick_per == 0);
        else if (tick_per == 0) sample_tick = ($urandom_range(2) == 0);
        else                    sample_tick = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        logic [63:0] ra, rb, rc;
        reset = 1'b1; pin_in = '0; filt_en = '0; filt_time = '0;
        sample_tick = 1'b0; latch_clr = '0; invert = '0;
        run("reset", 3);
        reset = 1'b0;
        run("idle", 4);
        expect_zero("reset_filt_data", filt_data);
        expect_zero("reset_rise_latch", rise_latch);
        expect_zero("reset_fall_latch", fall_latch);

        // Unfiltered pin 0: three clocks to filt_data, pulse on the fourth.
        pin_in[0] = 1'b1;
        run("p0", 2);
        expect_bit("p0_filt_clk2", filt_data[0], 1'b0);
        step("p0");
        expect_bit("p0_filt_clk3", filt_data[0], 1'b1);
        expect_bit("p0_rise_clk3", rise_pulse[0], 1'b0);
        step("p0");
        expect_bit("p0_rise_clk4", rise_pulse[0], 1'b1);
        step("p0");
        expect_bit("p0_rise_clk5", rise_pulse[0], 1'b0);
        expect_bit("p0_latch_clk5", rise_latch[0], 1'b1);

        // Pin 5 filtered, filt_time 4, tick every 10 clocks: short pulse rejected.
        filt_en[5] = 1'b1; filt_time = 8'd4; tick_per = 10;
        run("p5_pre", 5);
        pin_in[5] = 1'b1;
        run("p5_glitch", 25);
        pin_in[5] = 1'b0;
        run("p5_glitch", 30);
        expect_bit("p5_glitch_filt", filt_data[5], 1'b0);
        expect_bit("p5_glitch_latch", rise_latch[5], 1'b0);

        // Long pulse accepted, then release filtered the same way.
        pin_in[5] = 1'b1;
        run("p5_long", 60);
        expect_bit("p5_long_filt", filt_data[5], 1'b1);
        expect_bit("p5_long_latch", rise_latch[5], 1'b1);
        pin_in[5] = 1'b0;
        run("p5_rel", 60);
        expect_bit("p5_rel_filt", filt_data[5], 1'b0);
        expect_bit("p5_rel_latch", fall_latch[5], 1'b1);

        // Pin 7: clear coinciding with the rise pulse loses to the set.
        pin_in[7] = 1'b1;
        run("p7", 4);
        expect_bit("p7_pulse", rise_pulse[7], 1'b1);
        latch_clr[7] = 1'b1;
        step("p7_clr_set");
        expect_bit("p7_set_wins", rise_latch[7], 1'b1);
        step("p7_clr");
        expect_bit("p7_cleared", rise_latch[7], 1'b0);
        latch_clr[7] = 1'b0;

        // Pin 3 mid-count, then reset: level held after reset raises no edge.
        filt_en[3] = 1'b1; filt_time = 8'd8; pin_in[3] = 1'b1;
        run("p3_count", 28);
        expect_bit("p3_not_yet", filt_data[3], 1'b0);
        reset = 1'b1;
        step("p3_reset");
        expect_zero("p3_rst_filt", filt_data);
        expect_zero("p3_rst_rise", rise_latch);
        expect_zero("p3_rst_pulse", rise_pulse);
        reset = 1'b0;
        run("p3_after", 120);
        expect_bit("p3_filt", filt_data[3], 1'b1);
        expect_bit("p3_no_rise", rise_latch[3], 1'b0);

`ifdef GPIO_IN_INVERT_EN
        // Invert toggled on a low, unfiltered pin 9.
        invert[9] = 1'b1;
        step("p9_inv");
        expect_bit("p9_filt", filt_data[9], 1'b1);
        step("p9_inv");
        expect_bit("p9_rise", rise_pulse[9], 1'b1);
        step("p9_inv");
        expect_bit("p9_rise_once", rise_pulse[9], 1'b0);
        invert[9] = 1'b0;
        run("p9_inv", 4);
`endif

        // Randomized phase: sparse pin toggles, random ticks, clears and config changes.
        tick_per = 0;
        for (int c = 0; c < 3000; c++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = {$urandom(), $urandom()};
            pin_in    = pin_in ^ (ra[W-1:0] & rb[W-1:0] & rc[W-1:0]);
            latch_clr = rb[W-1:0] & rc[W-1:0];
            if (c % 200 == 0) filt_en = ra[W-1:0] | rc[W-1:0];
            if (c % 37 == 0)  filt_time = filt_cnt_t'($urandom_range(5));
`ifdef GPIO_IN_INVERT_EN
            if (c % 53 == 0)  invert = invert ^ (ra[W-1:0] & rb[W-1:0]);
`endif
            reset = (c % 900 == 899);
            step("random");
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
